// File: rtl/rv_dmem_resp.sv
// Data-memory responder: byte-lane masked stores and synchronous aligned loads with
// sign/zero extension; Q103H requests produce registered Q104H results.
module rv_dmem_resp #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_Q103H,
    input  logic        req_wr_Q103H,
    input  logic [31:0] req_addr_Q103H,
    input  logic [31:0] req_wr_data_Q103H,
    input  logic [1:0]  req_size_Q103H,
    input  logic        req_unsigned_Q103H,
    input  logic        stall_Q104H,
    output logic [31:0] dmem_rd_data_Q104H,
    output logic        rd_valid_Q104H,
    output logic        misaligned_Q104H
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic          accept;
    logic          illegal;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data_rep;
    logic          wr_en;

    logic          rd_valid_q, rd_valid_d;
    logic          misaligned_q, misaligned_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [31:0]   word_q;

    // Address bits above the array index are deliberately ignored (wrap-around).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_Q103H[31:AW+2];

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [31:0]        shifted;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        shifted = word >> {offset, 3'b000};
        b_s     = signed'(shifted[7:0]);
        h_s     = signed'(shifted[15:0]);
        case (size)
            2'd0:    load_extend = is_unsigned ? 32'(shifted[7:0])  : 32'(b_s);
            2'd1:    load_extend = is_unsigned ? 32'(shifted[15:0]) : 32'(h_s);
            default: load_extend = shifted;
        endcase
    endfunction

    always_comb begin
        word_idx = req_addr_Q103H[AW+1:2];
        off      = req_addr_Q103H[1:0];
        accept   = req_valid_Q103H && !stall_Q104H;

        illegal = 1'b0;
        case (req_size_Q103H)
            2'd0:    illegal = 1'b0;
            2'd1:    illegal = off[0];
            2'd2:    illegal = (off != 2'd0);
            default: illegal = 1'b1;
        endcase

        byte_en     = 4'b1111;
        wr_data_rep = req_wr_data_Q103H;
        case (req_size_Q103H)
            2'd0: begin
                byte_en     = 4'b0001 << off;
                wr_data_rep = {4{req_wr_data_Q103H[7:0]}};
            end
            2'd1: begin
                byte_en     = 4'b0011 << off;
                wr_data_rep = {2{req_wr_data_Q103H[15:0]}};
            end
            default: ;
        endcase

        wr_en = accept && req_wr_Q103H && !illegal;
    end

    // Q103H -> Q104H control: a stall freezes everything, otherwise track the new request.
    always_comb begin
        rd_valid_d   = rd_valid_q;
        misaligned_d = misaligned_q;
        off_d        = off_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        if (!stall_Q104H) begin
            rd_valid_d   = req_valid_Q103H && !req_wr_Q103H && !illegal;
            misaligned_d = req_valid_Q103H && illegal;
            if (req_valid_Q103H) begin
                off_d      = off;
                size_d     = req_size_Q103H;
                unsigned_d = req_unsigned_Q103H;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
        end else begin
            rd_valid_q   <= rd_valid_d;
            misaligned_q <= misaligned_d;
            off_q        <= off_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
        end
    end

    // Read-before-write at the same edge is fine: a store then a load of the
    // same word in the next cycle reads after the write has landed.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= mem[word_idx];
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data_rep[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        dmem_rd_data_Q104H = rd_valid_q ? load_extend(word_q, off_q, size_q, unsigned_q) : 32'd0;
        rd_valid_Q104H     = rd_valid_q;
        misaligned_Q104H   = misaligned_q;
    end

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed self-checking bench for rv_dmem_resp: stores, extended loads, illegal
// requests, stall hold, address wrap and asynchronous reset.
module tb_rv_dmem_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_Q103H;
    logic        req_wr_Q103H;
    logic [31:0] req_addr_Q103H;
    logic [31:0] req_wr_data_Q103H;
    logic [1:0]  req_size_Q103H;
    logic        req_unsigned_Q103H;
    logic        stall_Q104H;
    logic [31:0] dmem_rd_data_Q104H;
    logic        rd_valid_Q104H;
    logic        misaligned_Q104H;

    int checks = 0;
    int errors = 0;

    rv_dmem_resp #(.DEPTH_WORDS(1024)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_Q103H    (req_valid_Q103H),
        .req_wr_Q103H       (req_wr_Q103H),
        .req_addr_Q103H     (req_addr_Q103H),
        .req_wr_data_Q103H  (req_wr_data_Q103H),
        .req_size_Q103H     (req_size_Q103H),
        .req_unsigned_Q103H (req_unsigned_Q103H),
        .stall_Q104H        (stall_Q104H),
        .dmem_rd_data_Q104H (dmem_rd_data_Q104H),
        .rd_valid_Q104H     (rd_valid_Q104H),
        .misaligned_Q104H   (misaligned_Q104H)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] data, input logic vld, input logic mis);
        chk({tag, ".data"}, dmem_rd_data_Q104H, data);
        chk({tag, ".vld"},  {31'd0, rd_valid_Q104H}, {31'd0, vld});
        chk({tag, ".mis"},  {31'd0, misaligned_Q104H}, {31'd0, mis});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input logic uns);
        req_valid_Q103H    = 1'b1;
        req_wr_Q103H       = wr;
        req_addr_Q103H     = addr;
        req_wr_data_Q103H  = data;
        req_size_Q103H     = size;
        req_unsigned_Q103H = uns;
    endtask

    task automatic idle();
        req_valid_Q103H    = 1'b0;
        req_wr_Q103H       = 1'b0;
        req_addr_Q103H     = 32'd0;
        req_wr_data_Q103H  = 32'd0;
        req_size_Q103H     = 2'd0;
        req_unsigned_Q103H = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        stall_Q104H = 1'b0;
        idle();
        step();
        step();
        chk_out("reset", 32'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // word store then load next cycle
        req(1'b1, 32'h40, 32'hDEADBEEF, 2'd2, 1'b0); step();
        chk_out("st_word", 32'd0, 1'b0, 1'b0);
        req(1'b0, 32'h40, 32'd0, 2'd2, 1'b0); step();
        chk_out("ld_word", 32'hDEADBEEF, 1'b1, 1'b0);

        // byte store into 0x11223344 and extended byte loads
        req(1'b1, 32'h40, 32'h11223344, 2'd2, 1'b0); step();
        req(1'b1, 32'h41, 32'hAAAAAA80, 2'd0, 1'b0); step();
        req(1'b0, 32'h41, 32'd0, 2'd0, 1'b0); step();
        chk_out("ld_byte_s", 32'hFFFFFF80, 1'b1, 1'b0);
        req(1'b0, 32'h41, 32'd0, 2'd0, 1'b1); step();
        chk_out("ld_byte_u", 32'h00000080, 1'b1, 1'b0);
        req(1'b0, 32'h40, 32'd0, 2'd2, 1'b0); step();
        chk_out("ld_word_b", 32'h11228044, 1'b1, 1'b0);
        req(1'b0, 32'h43, 32'd0, 2'd0, 1'b0); step();
        chk_out("ld_byte3", 32'h00000011, 1'b1, 1'b0);

        // half loads and half store
        req(1'b1, 32'h44, 32'h80017FFF, 2'd2, 1'b0); step();
        req(1'b0, 32'h46, 32'd0, 2'd1, 1'b0); step();
        chk_out("ld_half_s", 32'hFFFF8001, 1'b1, 1'b0);
        req(1'b0, 32'h44, 32'd0, 2'd1, 1'b1); step();
        chk_out("ld_half_u", 32'h00007FFF, 1'b1, 1'b0);
        req(1'b0, 32'h44, 32'd0, 2'd1, 1'b0); step();
        chk_out("ld_half_s_pos", 32'h00007FFF, 1'b1, 1'b0);
        req(1'b1, 32'h46, 32'h1234BEEF, 2'd1, 1'b0); step();
        req(1'b0, 32'h44, 32'd0, 2'd2, 1'b0); step();
        chk_out("ld_word_h", 32'hBEEF7FFF, 1'b1, 1'b0);

        // misaligned / illegal requests
        req(1'b1, 32'h42, 32'h55555555, 2'd2, 1'b0); step();
        chk_out("st_misal", 32'd0, 1'b0, 1'b1);
        req(1'b0, 32'h40, 32'd0, 2'd2, 1'b0); step();
        chk_out("reread", 32'h11228044, 1'b1, 1'b0);
        req(1'b0, 32'h40, 32'd0, 2'd3, 1'b0); step();
        chk_out("size3", 32'd0, 1'b0, 1'b1);
        req(1'b0, 32'h41, 32'd0, 2'd1, 1'b0); step();
        chk_out("half_odd", 32'd0, 1'b0, 1'b1);
        req(1'b1, 32'h45, 32'hFFFFFFFF, 2'd1, 1'b0); step();
        chk_out("st_half_odd", 32'd0, 1'b0, 1'b1);
        req(1'b0, 32'h44, 32'd0, 2'd2, 1'b0); step();
        chk_out("reread_44", 32'hBEEF7FFF, 1'b1, 1'b0);

        // no request -> zeros
        idle(); step();
        chk_out("idle", 32'd0, 1'b0, 1'b0);

        // stall holds outputs and suppresses the write
        req(1'b0, 32'h40, 32'd0, 2'd2, 1'b0); step();
        chk_out("pre_stall", 32'h11228044, 1'b1, 1'b0);
        stall_Q104H = 1'b1;
        req(1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall%0d", i), 32'h11228044, 1'b1, 1'b0);
        end
        stall_Q104H = 1'b0; step();
        chk_out("post_stall_st", 32'd0, 1'b0, 1'b0);
        req(1'b0, 32'h40, 32'd0, 2'd2, 1'b0); step();
        chk_out("post_stall_ld", 32'hCAFEF00D, 1'b1, 1'b0);

        // stall during an illegal result holds misaligned
        req(1'b0, 32'h40, 32'd0, 2'd3, 1'b0); step();
        stall_Q104H = 1'b1;
        req(1'b0, 32'h44, 32'd0, 2'd2, 1'b0); step();
        chk_out("stall_mis", 32'd0, 1'b0, 1'b1);
        stall_Q104H = 1'b0; step();
        chk_out("after_mis", 32'hBEEF7FFF, 1'b1, 1'b0);

        // address wrap
        req(1'b1, 32'h1000, 32'h12345678, 2'd2, 1'b0); step();
        req(1'b0, 32'h0000, 32'd0, 2'd2, 1'b0); step();
        chk_out("wrap", 32'h12345678, 1'b1, 1'b0);

        // asynchronous reset mid-stream
        req(1'b0, 32'h40, 32'd0, 2'd0, 1'b1); step();
        chk_out("pre_rst", 32'h0000000D, 1'b1, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 32'd0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        req(1'b0, 32'h1002, 32'd0, 2'd1, 1'b0); step();
        chk_out("after_rst", 32'h00001234, 1'b1, 1'b0);
        idle(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
